// File: rtl/ula_controlador_if.sv
// Command and result handshake bundle between a command source and ula_controlador.
// The master drives commands and accepts results; the slave is the controller.
interface ula_controlador_if #(
  parameter int LARGURA = 4
);
  logic               Cmd_valido;
  logic               Cmd_pronto;
  logic [3:0]         Cmd_op;
  logic [LARGURA-1:0] Cmd_A;
  logic [LARGURA-1:0] Cmd_B;
  logic               Cmd_acum;
  logic               Res_valido;
  logic               Res_pronto;
  logic [LARGURA-1:0] Res_dado;
  logic               Res_erro;

  modport master (
    output Cmd_valido, Cmd_op, Cmd_A, Cmd_B, Cmd_acum, Res_pronto,
    input  Cmd_pronto, Res_valido, Res_dado, Res_erro
  );

  modport slave (
    input  Cmd_valido, Cmd_op, Cmd_A, Cmd_B, Cmd_acum, Res_pronto,
    output Cmd_pronto, Res_valido, Res_dado, Res_erro
  );
endinterface

// File: rtl/ula_controlador.sv
// Command-side driver for the combinational ALU: registers opcode/operands, samples
// the result one cycle later into a FWFT result FIFO and keeps a running accumulator.
//
// state  | meaning
// OCIOSO | waiting for a command; ALU inputs hold their last values
// EXEC   | ALU inputs stable for one cycle; Saida captured at the end of it
module ula_controlador #(
  parameter int LARGURA      = 4,
  parameter int PROFUNDIDADE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ula_controlador_if.slave     bus,
  output logic [3:0]           Entrada,
  output logic [LARGURA-1:0]   A,
  output logic [LARGURA-1:0]   B,
  input  logic [LARGURA-1:0]   Saida,
  output logic [LARGURA-1:0]   Acumulador,
  output logic                 Ocupado
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam logic [AW:0] CHEIO = (AW+1)'(PROFUNDIDADE);
  localparam logic [3:0]  OP_DIV = 4'b0011;

  typedef enum logic {
    OCIOSO = 1'b0,
    EXEC   = 1'b1
  } estado_t;

  estado_t estado, prox_estado;

  logic               aceita;
  logic               empurra;
  logic               retira;
  logic               div_zero;
  logic [LARGURA-1:0] resultado;

  logic [AW:0]        contagem;
  logic [AW-1:0]      ptr_esc;
  logic [AW-1:0]      ptr_leit;
  logic [LARGURA:0]   mem [PROFUNDIDADE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  always_comb begin
    prox_estado = estado;
    unique case (estado)
      OCIOSO: if (aceita) prox_estado = EXEC;
      EXEC:   prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  // Cmd_pronto is gated by rst_n so it drops in the same cycle reset is asserted.
  always_comb begin
    Ocupado        = (estado == EXEC);
    empurra        = (estado == EXEC);
    bus.Cmd_pronto = (estado == OCIOSO) && (contagem < CHEIO) && rst_n;
    aceita         = bus.Cmd_valido && bus.Cmd_pronto;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Entrada <= '0;
      A       <= '0;
      B       <= '0;
    end else if (aceita) begin
      Entrada <= bus.Cmd_op;
      A       <= bus.Cmd_acum ? Acumulador : bus.Cmd_A;
      B       <= bus.Cmd_B;
    end
  end

  // The ALU output is undefined for a zero divisor, so it never leaves this block.
  assign div_zero  = (Entrada == OP_DIV) && (B == '0);
  assign resultado = div_zero ? '0 : Saida;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Acumulador <= '0;
    end else if (empurra && !div_zero) begin
      Acumulador <= Saida;
    end
  end

  assign bus.Res_valido = (contagem != '0);
  assign retira         = bus.Res_valido && bus.Res_pronto;
  assign bus.Res_dado   = bus.Res_valido ? mem[ptr_leit][LARGURA-1:0] : '0;
  assign bus.Res_erro   = bus.Res_valido ? mem[ptr_leit][LARGURA] : 1'b0;

  always_ff @(posedge clk) begin
    if (empurra) begin
      mem[ptr_esc] <= {div_zero, resultado};
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_esc  <= '0;
      ptr_leit <= '0;
      contagem <= '0;
    end else begin
      if (empurra) ptr_esc  <= ptr_esc + 1'b1;
      if (retira)  ptr_leit <= ptr_leit + 1'b1;
      unique case ({empurra, retira})
        2'b10:   contagem <= contagem + 1'b1;
        2'b01:   contagem <= contagem - 1'b1;
        default: contagem <= contagem;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_controlador.sv
// Bench for ula_controlador: directed commands into a scoreboard queue, a monitor pops
// and compares whenever a result is handed over; a small ALU model closes the loop.
module tb_ula_controlador;
  localparam int L = 4;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_controlador_if #(.LARGURA(L)) bus();

  logic [3:0]   Entrada;
  logic [L-1:0] A, B, Saida, Acumulador;
  logic         Ocupado;

  ula_controlador #(.LARGURA(L), .PROFUNDIDADE(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .Entrada    (Entrada),
    .A          (A),
    .B          (B),
    .Saida      (Saida),
    .Acumulador (Acumulador),
    .Ocupado    (Ocupado)
  );

  // Stand-in ALU; a zero divisor yields 4'hF so an unguarded result would be visible.
  function automatic logic [3:0] alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    case (op)
      4'b0000: alu = a + b;
      4'b0001: alu = a - b;
      4'b0010: begin p = a * b; alu = p[3:0]; end
      4'b0011: alu = (b == 4'd0) ? 4'hF : a / b;
      4'b0100: alu = {a[2:0], 1'b0};
      4'b0101: alu = {1'b0, a[3:1]};
      4'b0110: alu = a & b;
      4'b0111: alu = a | b;
      4'b1000: alu = a ^ b;
      default: alu = a;
    endcase
  endfunction

  always_comb Saida = alu(Entrada, A, B);

  int checks = 0;
  int errors = 0;
  logic [4:0] esperado[$];
  logic [3:0] acc_model = 4'd0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.Res_valido === 1'b1 && bus.Res_pronto) begin
      if (esperado.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_spurious: got dado=%0d erro=%0d expected no result", bus.Res_dado, bus.Res_erro);
      end else begin
        logic [4:0] e;
        e = esperado.pop_front();
        chk("res_dado", 32'(bus.Res_dado), 32'(e[3:0]));
        chk("res_erro", 32'(bus.Res_erro), 32'(e[4]));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic acum);
    logic [3:0] aa, r;
    int t;
    bus.Cmd_valido = 1'b1;
    bus.Cmd_op     = op;
    bus.Cmd_A      = a;
    bus.Cmd_B      = b;
    bus.Cmd_acum   = acum;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.Cmd_pronto === 1'b1) break;
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got no accept expected accept of op=%0d", op);
        bus.Cmd_valido = 1'b0;
        return;
      end
    end
    aa = acum ? acc_model : a;
    r  = alu(op, aa, b);
    if (op == 4'b0011 && b == 4'd0) begin
      esperado.push_back({1'b1, 4'd0});
    end else begin
      esperado.push_back({1'b0, r});
      acc_model = r;
    end
    @(posedge clk);
    #1 bus.Cmd_valido = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (esperado.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1 chk("drain_empty", 32'(esperado.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Cmd_valido = 1'b0;
    bus.Cmd_op     = 4'd0;
    bus.Cmd_A      = 4'd0;
    bus.Cmd_B      = 4'd0;
    bus.Cmd_acum   = 1'b0;
    bus.Res_pronto = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_entrada", 32'(Entrada), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_b", 32'(B), 32'd0);
    chk("rst_acum", 32'(Acumulador), 32'd0);
    chk("rst_res_valido", 32'(bus.Res_valido), 32'd0);
    chk("rst_res_dado", 32'(bus.Res_dado), 32'd0);
    chk("rst_res_erro", 32'(bus.Res_erro), 32'd0);
    chk("rst_ocupado", 32'(Ocupado), 32'd0);
    chk("rst_cmd_pronto", 32'(bus.Cmd_pronto), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // first command and its latency
    issue(4'b0000, 4'd3, 4'd5, 1'b0);
    chk("lat_entrada", 32'(Entrada), 32'd0);
    chk("lat_a", 32'(A), 32'd3);
    chk("lat_b", 32'(B), 32'd5);
    chk("lat_ocupado", 32'(Ocupado), 32'd1);
    chk("lat_pronto_exec", 32'(bus.Cmd_pronto), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_res_valido", 32'(bus.Res_valido), 32'd1);
    chk("lat_acum", 32'(Acumulador), 32'd8);
    chk("lat_ocupado_off", 32'(Ocupado), 32'd0);
    chk("lat_pronto_back", 32'(bus.Cmd_pronto), 32'd1);

    // accumulator chain: 7, 7+12=3, 3<<1=6
    issue(4'b0000, 4'd7, 4'd0, 1'b0);
    issue(4'b0000, 4'd0, 4'd12, 1'b1);
    issue(4'b0100, 4'd0, 4'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("chain_acum", 32'(Acumulador), 32'd6);

    // divide by zero keeps the accumulator
    issue(4'b0011, 4'd9, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("div0_acum", 32'(Acumulador), 32'd6);
    issue(4'b0011, 4'd9, 4'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("div_acum", 32'(Acumulador), 32'd4);
    wait_drain();

    // back-pressure: four fill the FIFO, fifth waits for one pop
    bus.Res_pronto = 1'b0;
    for (int i = 0; i < 4; i++) issue(4'b0000, 4'(i), 4'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("full_res_valido", 32'(bus.Res_valido), 32'd1);
    chk("full_cmd_pronto", 32'(bus.Cmd_pronto), 32'd0);
    fork
      issue(4'b0000, 4'd9, 4'd9, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_hold_pronto", 32'(bus.Cmd_pronto), 32'd0);
        end
        @(posedge clk);
        #1 bus.Res_pronto = 1'b1;
        @(posedge clk);
        #1 bus.Res_pronto = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1 chk("bp_res_valido", 32'(bus.Res_valido), 32'd1);
    bus.Res_pronto = 1'b1;
    wait_drain();

    // simultaneous push and pop with two entries preloaded
    bus.Res_pronto = 1'b0;
    issue(4'b0110, 4'hC, 4'hA, 1'b0);
    issue(4'b0111, 4'd5, 4'd2, 1'b0);
    repeat (2) @(posedge clk);
    #1 bus.Res_pronto = 1'b1;
    issue(4'b1000, 4'hF, 4'd3, 1'b0);
    issue(4'b0001, 4'd2, 4'd5, 1'b0);
    issue(4'b0010, 4'd3, 4'd7, 1'b0);
    issue(4'b0101, 4'd8, 4'd0, 1'b0);
    wait_drain();
    repeat (2) @(posedge clk);
    #1 chk("sim_empty", 32'(bus.Res_valido), 32'd0);

    // reset during EXEC drops the in-flight command
    issue(4'b0001, 4'd5, 4'd1, 1'b0);
    chk("midrst_busy", 32'(Ocupado), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valido", 32'(bus.Res_valido), 32'd0);
    chk("midrst_ocupado", 32'(Ocupado), 32'd0);
    chk("midrst_entrada", 32'(Entrada), 32'd0);
    chk("midrst_a", 32'(A), 32'd0);
    chk("midrst_b", 32'(B), 32'd0);
    chk("midrst_pronto", 32'(bus.Cmd_pronto), 32'd0);
    chk("midrst_acum", 32'(Acumulador), 32'd0);
    esperado.delete();
    acc_model = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("postrst_empty", 32'(bus.Res_valido), 32'd0);
    issue(4'b0000, 4'd2, 4'd2, 1'b1);
    wait_drain();
    #1 chk("postrst_acum", 32'(Acumulador), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
